// File: rtl/tri_buffer.sv
// Double-buffered triangle store between the projection stage and the rasterizer.
// Optional BACKFACE_CULL_EN drops triangles whose signed screen-space area is <= 0.
module tri_buffer #(
  parameter int unsigned MAX_TRIS = 16,
  parameter int unsigned COORD_W  = 9,
  localparam int unsigned IDX_W   = $clog2(MAX_TRIS + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [2:0][COORD_W-1:0] vert1,
  input  logic [2:0][COORD_W-1:0] vert2,
  input  logic [2:0][COORD_W-1:0] vert3,
  input  logic                    valid_in,
  input  logic                    obj_done_in,
  output logic                    ready_out,
  input  logic                    new_frame,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [2:0][COORD_W-1:0] rd_vert1,
  output logic [2:0][COORD_W-1:0] rd_vert2,
  output logic [2:0][COORD_W-1:0] rd_vert3,
  output logic                    rd_hit,
  output logic [IDX_W-1:0]        front_count,
  output logic                    front_valid,
  output logic                    overflow
);

  localparam int unsigned AddrW = $clog2(2 * MAX_TRIS);

  typedef struct packed {
    logic [2:0][COORD_W-1:0] v1;
    logic [2:0][COORD_W-1:0] v2;
    logic [2:0][COORD_W-1:0] v3;
  } tri_t;

  typedef enum logic [0:0] {StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] back_count_q, back_count_d;
  logic [IDX_W-1:0] front_count_q, front_count_d;
  logic             front_valid_q, front_valid_d;
  logic             overflow_q, overflow_d;
  logic             bank_q, bank_d;
  tri_t             rd_tri_q, rd_tri_d;
  logic             rd_hit_q, rd_hit_d;

  tri_t             mem_q [2*MAX_TRIS];
  tri_t             wr_tri;
  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [AddrW-1:0] rd_addr;
  logic             accept;
  logic             cull;

`ifdef BACKFACE_CULL_EN
  localparam int unsigned AreaW = 2 * COORD_W + 3;

  // Coordinates are unsigned; zero-extend before the signed area arithmetic.
  logic signed [AreaW-1:0] ax1, ay1, ax2, ay2, ax3, ay3, area;

  always_comb begin
    ax1  = AreaW'(vert1[0]);
    ay1  = AreaW'(vert1[1]);
    ax2  = AreaW'(vert2[0]);
    ay2  = AreaW'(vert2[1]);
    ax3  = AreaW'(vert3[0]);
    ay3  = AreaW'(vert3[1]);
    area = (ax2 - ax1) * (ay3 - ay1) - (ax3 - ax1) * (ay2 - ay1);
    cull = area[AreaW-1] | (area == '0);
  end
`else
  assign cull = 1'b0;
`endif

  assign ready_out = (state_q == StFill);
  assign accept    = valid_in & ready_out;
  assign wr_tri    = '{v1: vert1, v2: vert2, v3: vert3};

  // Front bank is bank_q; the back bank is the other half of the storage.
  assign wr_addr = AddrW'(back_count_q) + (bank_q ? AddrW'(0) : AddrW'(MAX_TRIS));
  assign rd_addr = AddrW'(rd_idx) + (bank_q ? AddrW'(MAX_TRIS) : AddrW'(0));

  always_comb begin
    state_d       = state_q;
    back_count_d  = back_count_q;
    front_count_d = front_count_q;
    front_valid_d = front_valid_q;
    overflow_d    = overflow_q;
    bank_d        = bank_q;
    wr_en         = 1'b0;
    case (state_q)
      StFill: begin
        if (accept && !cull) begin
          if (back_count_q < IDX_W'(MAX_TRIS)) begin
            wr_en        = 1'b1;
            back_count_d = back_count_q + IDX_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (obj_done_in) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (new_frame) begin
          bank_d        = ~bank_q;
          front_count_d = back_count_q;
          front_valid_d = 1'b1;
          back_count_d  = '0;
          state_d       = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    rd_hit_d = (rd_idx < front_count_q);
    rd_tri_d = rd_hit_d ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= StFill;
      back_count_q  <= '0;
      front_count_q <= '0;
      front_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      bank_q        <= 1'b0;
      rd_tri_q      <= '0;
      rd_hit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      back_count_q  <= back_count_d;
      front_count_q <= front_count_d;
      front_valid_q <= front_valid_d;
      overflow_q    <= overflow_d;
      bank_q        <= bank_d;
      rd_tri_q      <= rd_tri_d;
      rd_hit_q      <= rd_hit_d;
    end
  end

  // Storage needs no reset; only entries below the counts are ever read out.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_tri;
    end
  end

  assign rd_vert1    = rd_tri_q.v1;
  assign rd_vert2    = rd_tri_q.v2;
  assign rd_vert3    = rd_tri_q.v3;
  assign rd_hit      = rd_hit_q;
  assign front_count = front_count_q;
  assign front_valid = front_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/tri_buffer.md
Name: tri_buffer

Overview:
- Receiving end of the projected-triangle stream (valid/ready/obj_done) produced by the tri_proj stage.
- Collects one object's screen-space triangles into a back bank.
- On new_frame, swaps the back bank to the front.
- Serves front-bank triangles by index to the rasterizer, decoupling triangle arrival from pixel scan.
- Double-buffered, so the rasterizer always reads a complete object while the next one streams in.

Parameters:
- MAX_TRIS, 16, triangle capacity per bank; IDX_W = $clog2(MAX_TRIS+1).
- COORD_W, 9, width of each vertex component; index 0=x, 1=y, 2=depth.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- vert1  in  3 x COORD_W  vertex 1 {x,y,depth}.
- vert2  in  3 x COORD_W  vertex 2.
- vert3  in  3 x COORD_W  vertex 3.
- valid_in  in  1  triangle beat valid.
- obj_done_in  in  1  object complete; see Behaviour.
- ready_out  out  1  buffer accepts beats.
- new_frame  in  1  single-cycle frame-start pulse from video timing.
- rd_idx  in  IDX_W  front-bank triangle index requested by the rasterizer.
- rd_vert1, rd_vert2, rd_vert3  out  3 x COORD_W each  front-bank triangle at rd_idx.
- rd_hit  out  1  rd_idx < front_count; the rd_vert outputs are valid.
- front_count  out  IDX_W  number of triangles in the front bank.
- front_valid  out  1  the front bank holds a completed object.
- overflow  out  1  sticky; a triangle was dropped because the back bank was full.

Behaviour:
- Reset (rst_in=0, async): state=FILL; back_count=0; front_count=0; front_valid=0; overflow=0; rd_vert* = 0; rd_hit=0. Bank select=0. Storage contents are don't-care.
- States: FILL, DONE.
- FILL:
  - ready_out=1.
  - Accept beat = valid_in & ready_out.
  - If accepted and back_count<MAX_TRIS: write the triangle at back[back_count]; back_count+1.
  - If accepted and back_count==MAX_TRIS: drop the triangle; set overflow; count is unchanged.
  - obj_done_in is sampled every FILL cycle, with or without valid_in.
  - When obj_done_in=1, any beat accepted in the same cycle is stored first, then the state goes to DONE.
  - An object with zero triangles is legal.
- DONE:
  - ready_out=0; upstream must hold its data.
  - On new_frame=1, at that edge: bank select toggles; front_count<=back_count (including any beat written earlier); front_valid<=1; back_count<=0; state goes to FILL.
- new_frame while in FILL: ignored; the front bank is unchanged. The pulse is not remembered.
- obj_done beat and new_frame in the same FILL cycle: go to DONE; no swap. The swap occurs on the next new_frame.
- Read port:
  - Registered, latency 1: rd_vert*/rd_hit at cycle N+1 reflect rd_idx at cycle N, using the bank select in effect at cycle N.
  - rd_idx>=front_count gives rd_vert*=0, rd_hit=0.
- overflow is cleared only by reset.
- Storage: 2 x MAX_TRIS x 9 x COORD_W flops or distributed RAM, with one write port and one read port.
- Reset mid-operation: returns to reset values immediately. Any partial object is discarded.

Optional Feature:
- Macro: BACKFACE_CULL_EN.
- When defined, each accepted triangle gets a signed area computed in signed (2*COORD_W+3)-bit arithmetic, coordinates treated as unsigned: A = (x2-x1)*(y3-y1) - (x3-x1)*(y2-y1).
- If A<=0, the triangle is culled: not written, back_count unchanged, overflow unaffected.
- Culling is combinational in the accept cycle; throughput and latency are unchanged. obj_done handling is unchanged.
- When undefined, all accepted triangles are stored.

Test Plan:
- Reset, stream 3 triangles; obj_done on 3rd beat; pulse new_frame -> front_count=3, front_valid=1, rd_idx=1 returns 2nd triangle one cycle later, rd_idx=3 -> rd_hit=0, rd_vert*=0.
- Stream 18 triangles with MAX_TRIS=16, then obj_done and new_frame -> front_count=16, overflow=1, triangles 17-18 absent.
- After obj_done, hold valid_in=1 for 10 cycles before new_frame -> ready_out=0 throughout; next object begins accepting the cycle after the swap; front bank reads stay stable during refill.
- obj_done_in alone with no valid_in, then new_frame -> front_count=0, front_valid=1; new_frame during FILL -> front_count unchanged.
- Same-cycle obj_done beat + new_frame -> no swap; swap on following new_frame. Assert rst_in low mid-stream -> ready_out=1, counts=0, front_valid=0, overflow=0 asynchronously.
- BACKFACE_CULL_EN: send CCW (0,0),(10,0),(0,10), then CW (0,0),(0,10),(10,0), then degenerate (all vertices equal) -> front_count=1; without macro -> front_count=3.
